// File: rtl/store_pkg.sv
// store_pkg: FSM states, store size codes and lane-mask helper for store_merge_unit
package store_pkg;

    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_MERGE, ST_WRITE, ST_DONE} st_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        return size == SZ_B ? 64'hFF : size == SZ_H ? 64'hFFFF : size == SZ_W ? 64'hFFFF_FFFF : '1;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: overlays the addressed store lanes onto a read memory word
module store_lane_merge
    import store_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    input  logic [1:0]  size,
    input  logic [2:0]  off,
    output logic [63:0] merged
);

    logic [63:0] mask;

    // shift mask and payload to the byte offset; payload bits above the size fall outside the mask
    always_comb begin
        mask   = size_mask(size) << {off, 3'b000};
        merged = (rdata & ~mask) | ((wdata << {off, 3'b000}) & mask);
    end

endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: store sequencer (direct sd write, read-modify-write for sb/sh/sw); STORE_MISALIGN_TRAP_EN enables the misalignment trap
module store_merge_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    output logic        busy,
    output logic        done
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int CW = $clog2(MEM_LAT + 1);

    st_t           state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    size_q, size_d;
    logic [63:0]   addr_q, addr_d, data_q, data_d, wdata_q, wdata_d, merged;
    logic [2:0]    off;
    logic          bad;
    logic          unused_funct3;

    assign unused_funct3 = funct3[2];

`ifdef STORE_MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign bad = funct3[1:0] == SZ_H ? addr[0] : funct3[1:0] == SZ_W ? |addr[1:0] :
                 funct3[1:0] == SZ_D ? |addr[2:0] : 1'b0;

    // error flag sets on a trapped request and holds until reset
    always_comb mis_d = mis_q | (state_q == ST_IDLE && start && bad);

    // sticky error register
    always_ff @(posedge clk) mis_q <= reset ? 1'b0 : mis_d;

    assign misaligned = mis_q;
`else
    assign bad = 1'b0;
`endif

    // natural alignment: drop offset bits below the access size
    assign off = addr_q[2:0] & (size_q == SZ_B ? 3'b111 : size_q == SZ_H ? 3'b110 :
                                size_q == SZ_W ? 3'b100 : 3'b000);

    store_lane_merge u_merge (
        .rdata  (mem_rdata),
        .wdata  (data_q),
        .size   (size_q),
        .off    (off),
        .merged (merged)
    );

    // next-state and register updates for the store sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: if (start) begin
                size_d  = funct3[1:0];
                addr_d  = addr;
                data_d  = store_data;
                cnt_d   = '0;
                wdata_d = store_data;
                state_d = bad ? ST_DONE : funct3[1:0] == SZ_D ? ST_WRITE : ST_READ;
            end
            ST_READ: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(MEM_LAT - 1) ? ST_MERGE : ST_READ;
            end
            ST_MERGE: begin
                wdata_d = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wr    = state_q == ST_WRITE;
    assign mem_wdata = wdata_q;
    assign busy      = state_q == ST_READ || state_q == ST_MERGE || state_q == ST_WRITE;
    assign done      = state_q == ST_DONE;

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed store requests checked cycle by cycle against a schedule/byte-lane model
module tb_store_merge_unit;

    localparam int LAT = 3;
    localparam logic [63:0] JUNK = 64'hC3C3_5A5A_0F0F_9696;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [63:0] addr = '0, store_data = '0;
    logic [63:0] mem_rdata, mem_addr, mem_wdata;
    logic        mem_wr, busy, done;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        misaligned;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int cyc = 0, vectors = 0, miscompares = 0;
    int s_c = 0, wr_c = -1, done_c = -1, b_lo = 1, b_hi = 0, rd_c = -1, mis_c = -1;
    int last_wr_c = -1, last_done_c = -1;
    logic [63:0] rd_word = '0, exp_wd = '0, exp_addr = '0, last_wd = '0;
    bit chk = 1'b0;

    store_merge_unit #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory returns the requested word only in the cycle its latency expires
    assign mem_rdata = (cyc == rd_c) ? rd_word : JUNK;

    function automatic logic [63:0] model(input logic [1:0] sz, input logic [63:0] a, d, w);
        int nb = 1 << sz;
        int off = (int'(a[2:0]) / nb) * nb;
        logic [63:0] r = w;
        if (sz == 2'd3) return d;
        for (int i = 0; i < nb; i++) r[8*(off+i) +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) if (chk) begin
        check("mem_wr", mem_wr, cyc == wr_c);
        check("done", done, cyc == done_c);
        check("busy", busy, cyc >= b_lo && cyc <= b_hi);
        if (wr_c >= 0 && cyc == wr_c) check("mem_wdata", mem_wdata, exp_wd);
        if (wr_c >= 0 && cyc >= b_lo && cyc <= wr_c) check("mem_addr", mem_addr, exp_addr);
`ifdef STORE_MISALIGN_TRAP_EN
        check("misaligned", misaligned, mis_c >= 0 && cyc >= mis_c);
`endif
        if (mem_wr) begin
            last_wd   = mem_wdata;
            last_wr_c = cyc;
        end
        if (done) last_done_c = cyc;
    end

    task automatic req(input logic [1:0] sz, input logic [63:0] a, d, w, input int abort, input bit poke);
        bit bad;
        @(posedge clk); #1;
        bad = TRAP && ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (sz == 2'd3 && a[2:0] != 0));
        s_c = cyc;
        start = 1'b1; funct3 = {1'b0, sz}; addr = a; store_data = d; rd_word = w;
        exp_wd = model(sz, a, d, w);
        exp_addr = {a[63:3], 3'b000};
        b_lo = s_c + 1;
        if (bad) begin
            wr_c = -1; done_c = s_c + 1; b_hi = s_c; rd_c = -1; mis_c = s_c + 1;
        end else begin
            wr_c   = (sz == 2'd3) ? s_c + 1 : s_c + LAT + 2;
            done_c = wr_c + 1;
            b_hi   = wr_c;
            rd_c   = (sz == 2'd3) ? -1 : s_c + LAT + 1;
        end
        @(posedge clk); #1;
        start = 1'b0; addr = JUNK; store_data = ~JUNK; funct3 = 3'b011;
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (abort > 0) begin
            repeat (abort - 1) @(posedge clk);
            #1;
            reset = 1'b1; b_hi = cyc; wr_c = -1; done_c = -1; rd_c = -1;
            @(posedge clk); #1;
            reset = 1'b0; mis_c = -1;
        end else begin
            while (cyc < done_c) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk = 1'b1;
        @(negedge clk); #1;
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        req(2'd3, 64'h100, 64'h1122_3344_5566_7788, '1, 0, 0);
        @(negedge clk); #1;
        check("sd_wdata", last_wd, 64'h1122_3344_5566_7788);
        check("sd_wr_lat", last_wr_c - s_c, 1);
        check("sd_done_lat", last_done_c - s_c, 2);

        req(2'd0, 64'h103, 64'hAB, '1, 0, 0);
        @(negedge clk); #1;
        check("sb_wdata", last_wd, 64'hFFFF_FFFF_ABFF_FFFF);
        check("sb_done_lat", last_done_c - s_c, 6);

        req(2'd2, 64'h204, 64'hDEAD_BEEF, 64'h0, 0, 0);
        @(negedge clk); #1;
        check("sw_wdata", last_wd, 64'hDEAD_BEEF_0000_0000);
        check("sw_wr_lat", last_wr_c - s_c, 5);

        req(2'd1, 64'h101, 64'h1234_5678_9ABC_BEEF, 64'h0011_2233_4455_6677, 0, 0);
        @(negedge clk); #1;
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_sh_done_lat", last_done_c - s_c, 1);
        check("mis_sh_no_write", last_wr_c >= s_c, 1'b0);
        check("mis_sh_flag", misaligned, 1'b1);
`else
        check("mis_sh_wdata", last_wd, 64'h0011_2233_4455_BEEF);
`endif

        req(2'd1, 64'h10A, 64'hFFFF_FFFF_FFFF_CAFE, 64'h0, 0, 0);
        @(negedge clk); #1;
        check("sh_wdata", last_wd, 64'h0000_0000_CAFE_0000);

        req(2'd0, 64'h7, 64'h5A, 64'h0102_0304_0506_0708, 0, 0);
        @(negedge clk); #1;
        check("sb_top_wdata", last_wd, 64'h5A02_0304_0506_0708);

        req(2'd0, 64'h40, 64'h11, 64'h0, 2, 0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_write", last_wr_c >= s_c, 1'b0);
        check("abort_busy", busy, 1'b0);

        req(2'd0, 64'h40, 64'h77, '1, 0, 0);
        @(negedge clk); #1;
        check("post_rst_sb_wdata", last_wd, 64'hFFFF_FFFF_FFFF_FF77);

        req(2'd2, 64'h10, 64'h0BAD_F00D, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("poke_wdata", last_wd, 64'hAAAA_AAAA_0BAD_F00D);
        check("poke_single_done", last_done_c - s_c, 6);

        req(2'd3, 64'h105, 64'h0102_0304_0506_0708, '1, 0, 0);
        @(negedge clk); #1;
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_sd_no_write", last_wr_c >= s_c, 1'b0);
`else
        check("mis_sd_wdata", last_wd, 64'h0102_0304_0506_0708);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
